// File: rtl/edge_threshold.sv
// Binarises a show-ahead stream of Sobel magnitudes into 00/FF pixels, zeroing the image border,
// and reports per-frame edge count and interior maximum through a one-cycle REPORT state.
//
// state  | meaning
// RUN    | pass pixels whenever source has data and sink has room
// REPORT | one idle cycle after the last pixel; frame_done high, results latched
module edge_threshold #(
  parameter int         WIDTH     = 720,
  parameter int         HEIGHT    = 540,
  parameter logic [7:0] THRESHOLD = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [7:0]  in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [7:0]  out_din,
  output logic        frame_done,
  output logic [19:0] frame_edges,
  output logic [7:0]  frame_max
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  typedef enum logic {RUN = 1'b0, REPORT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [19:0]   cnt_q, cnt_d;
  logic [7:0]    max_q, max_d;
  logic [19:0]   edges_q, edges_d;
  logic [7:0]    fmax_q, fmax_d;

  logic        xfer;
  logic        is_border;
  logic        is_edge;
  logic        is_last;
  logic [19:0] cnt_inc;
  logic [7:0]  max_upd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      col_q   <= '0;
      row_q   <= '0;
      cnt_q   <= '0;
      max_q   <= '0;
      edges_q <= '0;
      fmax_q  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      max_q   <= max_d;
      edges_q <= edges_d;
      fmax_q  <= fmax_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (xfer && is_last) state_d = REPORT;
      REPORT:  state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Reset input gates the strobes directly so upstream never sees a pop while held in reset.
  always_comb begin
    xfer        = rst && (state_q == RUN) && !in_empty && !out_full;
    in_rd_en    = xfer;
    out_wr_en   = xfer;
    frame_done  = (state_q == REPORT);
    out_din     = is_edge ? 8'hFF : 8'h00;
    frame_edges = edges_q;
    frame_max   = fmax_q;
  end

  always_comb begin
    is_border = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);
    is_edge   = !is_border && (in_dout >= THRESHOLD);
    is_last   = (col_q == COL_LAST) && (row_q == ROW_LAST);
    cnt_inc   = (is_edge && (cnt_q != 20'hFFFFF)) ? cnt_q + 20'd1 : cnt_q;
    max_upd   = (!is_border && (in_dout > max_q)) ? in_dout : max_q;
  end

  // Final pixel's contribution goes straight into the latched results.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    edges_d = edges_q;
    fmax_d  = fmax_q;
    if (xfer) begin
      if (is_last) begin
        col_d   = '0;
        row_d   = '0;
        cnt_d   = '0;
        max_d   = '0;
        edges_d = cnt_inc;
        fmax_d  = max_upd;
      end else begin
        cnt_d = cnt_inc;
        max_d = max_upd;
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_threshold.sv
// Randomised and directed bench for edge_threshold at 4x3; a pixel-index model predicts every
// strobe, output pixel and frame result each cycle, with literal checks pinning the model.
module tb_edge_threshold;

  localparam int         W  = 4;
  localparam int         H  = 3;
  localparam logic [7:0] TH = 8'd64;
  localparam int         NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_rd_en;
  logic        in_empty = 1'b1;
  logic [7:0]  in_dout = 8'h00;
  logic        out_wr_en;
  logic        out_full = 1'b0;
  logic [7:0]  out_din;
  logic        frame_done;
  logic [19:0] frame_edges;
  logic [7:0]  frame_max;

  edge_threshold #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(TH)) dut (
    .clk(clk), .rst(rst),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
    .frame_done(frame_done), .frame_edges(frame_edges), .frame_max(frame_max)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model state
  int          m_pix = 0;
  int          m_cnt = 0;
  int          m_max = 0;
  int          m_edges = 0;
  int          m_fmax = 0;
  bit          m_report = 0;
  int          frames_done = 0;
  bit          took = 0;
  logic [7:0]  outs[$];
  int          done_edges[$];
  int          done_max[$];

  // stimulus state
  logic [7:0]  src[$];
  int          full_mode = 0;   // 0 none, 1 toggle, 2 random
  bit          empty_rand = 0;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_rd_en", in_rd_en, 0);
      chk("rst_wr_en", out_wr_en, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_edges", frame_edges, 0);
      chk("rst_max", frame_max, 0);
      m_pix = 0; m_cnt = 0; m_max = 0; m_edges = 0; m_fmax = 0;
      m_report = 0; took = 0;
    end else begin
      automatic bit exp_x = !m_report && !in_empty && !out_full;
      chk("rd_en", in_rd_en, exp_x);
      chk("wr_en", out_wr_en, exp_x);
      chk("frame_done", frame_done, m_report);
      chk("frame_edges", frame_edges, m_edges);
      chk("frame_max", frame_max, m_fmax);
      took = in_rd_en;
      if (m_report) begin
        m_report = 0;
      end else if (exp_x) begin
        automatic int r = m_pix / W;
        automatic int c = m_pix % W;
        automatic bit border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
        automatic bit e = !border && (in_dout >= TH);
        chk("out_din", out_din, e ? 8'hFF : 8'h00);
        outs.push_back(out_din);
        if (e && m_cnt < 20'hFFFFF) m_cnt++;
        if (!border && int'(in_dout) > m_max) m_max = in_dout;
        m_pix++;
        if (m_pix == NPIX) begin
          m_edges = m_cnt; m_fmax = m_max;
          m_cnt = 0; m_max = 0; m_pix = 0;
          m_report = 1;
          frames_done++;
        end
      end
      if (frame_done) begin
        done_edges.push_back(frame_edges);
        done_max.push_back(frame_max);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (took && src.size() > 0) void'(src.pop_front());
    in_dout  = (src.size() > 0) ? src[0] : 8'($urandom);
    in_empty = (src.size() == 0) || (empty_rand && $urandom_range(0, 2) == 0);
    case (full_mode)
      1:       out_full = ~out_full;
      2:       out_full = ($urandom_range(0, 3) == 0);
      default: out_full = 1'b0;
    endcase
  endtask

  task automatic wait_frames(input int n);
    automatic int target = frames_done + n;
    automatic int budget = 400 * n;
    while (frames_done < target && budget > 0) begin
      cycle();
      budget--;
    end
    chk("frame_timeout", (frames_done >= target), 1);
    cycle();
    cycle();
  endtask

  task automatic load(input logic [7:0] border_v, input logic [7:0] i0, input logic [7:0] i1);
    for (int i = 0; i < NPIX; i++) begin
      if (i == 5) src.push_back(i0);
      else if (i == 6) src.push_back(i1);
      else src.push_back(border_v);
    end
  endtask

  task automatic chk_stream(input string name, input bit i5, input bit i6);
    chk({name, "_len"}, outs.size(), NPIX);
    for (int i = 0; i < NPIX && i < outs.size(); i++)
      chk(name, outs[i], ((i == 5 && i5) || (i == 6 && i6)) ? 8'hFF : 8'h00);
  endtask

  initial begin
    repeat (3) cycle();
    #1 rst = 1'b1;

    // all 200: edges 2, max 200
    outs.delete(); load(8'd200, 8'd200, 8'd200); wait_frames(1);
    chk_stream("s200", 1, 1);
    chk("lit_edges_200", frame_edges, 2);
    chk("lit_max_200", frame_max, 200);

    // threshold boundary 63/64
    outs.delete(); load(8'd0, 8'd63, 8'd64); wait_frames(1);
    chk_stream("s6364", 0, 1);
    chk("lit_edges_6364", frame_edges, 1);
    chk("lit_max_6364", frame_max, 64);

    // bright border ignored
    outs.delete(); load(8'd255, 8'd10, 8'd10); wait_frames(1);
    chk_stream("sborder", 0, 0);
    chk("lit_edges_border", frame_edges, 0);
    chk("lit_max_border", frame_max, 10);

    // toggled full and random empty
    full_mode = 1; empty_rand = 1;
    outs.delete(); load(8'd200, 8'd200, 8'd200); wait_frames(1);
    chk_stream("sstall", 1, 1);
    chk("lit_edges_stall", frame_edges, 2);
    chk("lit_max_stall", frame_max, 200);
    full_mode = 0; empty_rand = 0;

    // reset after 7 pixels, then clean frame
    begin
      automatic int f0 = frames_done;
      automatic int budget = 100;
      outs.delete(); load(8'd200, 8'd200, 8'd200);
      while (outs.size() < 7 && budget > 0) begin cycle(); budget--; end
      chk("partial_reached", outs.size(), 7);
      @(posedge clk); #1;
      rst = 1'b0; src.delete(); in_empty = 1'b1;
      repeat (2) cycle();
      #1 rst = 1'b1;
      chk("no_partial_done", frames_done, f0);
      outs.delete(); load(8'd200, 8'd200, 8'd200); wait_frames(1);
      chk_stream("spost", 1, 1);
      chk("lit_edges_post", frame_edges, 2);
      chk("lit_max_post", frame_max, 200);
    end

    // back-to-back frames
    outs.delete(); done_edges.delete(); done_max.delete();
    load(8'd200, 8'd200, 8'd200); load(8'd255, 8'd10, 8'd10);
    wait_frames(2);
    chk("b2b_pixels", outs.size(), 2 * NPIX);
    chk("b2b_ndone", done_edges.size(), 2);
    if (done_edges.size() == 2) begin
      chk("b2b_edges0", done_edges[0], 2);
      chk("b2b_max0", done_max[0], 200);
      chk("b2b_edges1", done_edges[1], 0);
      chk("b2b_max1", done_max[1], 10);
    end

    // random frames and stalls
    for (int f = 0; f < 30; f++) begin
      full_mode  = $urandom_range(0, 2);
      empty_rand = $urandom_range(0, 1);
      for (int i = 0; i < NPIX; i++)
        src.push_back(($urandom_range(0, 1) == 1) ? 8'($urandom_range(54, 74)) : 8'($urandom));
      wait_frames(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
